// File: rtl/wait_pkg.sv
// Shared types and defaults for the 8284A READY wait-state generator.
package wait_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    EXTEND = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int DEF_IO_WAITS  = 1;
  localparam int DEF_MEM_WAITS = 0;
  localparam int DEF_DMA_WAITS = 1;
  localparam int DEF_TIMEOUT   = 64;
  localparam int DEF_CNT_W     = 7;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous board inputs.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/wait_state_gen.sv
// READY wait-state generator: drives 8284A RDY1/AEN1 from 8288 strobes
// and the I/O channel ready line, with a bus-hang timeout.
module wait_state_gen
  import wait_pkg::*;
#(
  parameter int IO_WAITS  = DEF_IO_WAITS,
  parameter int MEM_WAITS = DEF_MEM_WAITS,
  parameter int DMA_WAITS = DEF_DMA_WAITS,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic ior_n,
  input  logic iow_n,
  input  logic memr_n,
  input  logic memw_n,
  input  logic dma_ack,
  input  logic io_ch_rdy,
  output logic rdy1,
  output logic aen1,
  output logic timeout_err
);

  localparam logic [CNT_W-1:0] IOW  = CNT_W'(IO_WAITS);
  localparam logic [CNT_W-1:0] MEMW = CNT_W'(MEM_WAITS);
  localparam logic [CNT_W-1:0] DMAW = CNT_W'(DMA_WAITS);
  localparam logic [CNT_W-1:0] TLIM = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] wcnt;
  logic [CNT_W-1:0] tcnt;
  logic [CNT_W-1:0] n;
  logic             rdy_s;
  logic             cmd_io;
  logic             cmd_mem;
  logic             cmd;
  logic             cmd_prev;
  logic             armed;
  logic             start;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (io_ch_rdy),
    .q     (rdy_s)
  );

  assign cmd_io  = ~ior_n | ~iow_n;
  assign cmd_mem = ~memr_n | ~memw_n;
  assign cmd     = cmd_io | cmd_mem;
  // armed blocks a strobe still low across reset release
  assign start   = cmd & ~cmd_prev & en & armed;

  always_comb begin
    n = cmd_io ? IOW : MEMW;
    if (dma_ack)
      n = n + DMAW;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rdy1        <= 1'b1;
      aen1        <= 1'b1;
      timeout_err <= 1'b0;
      wcnt        <= '0;
      tcnt        <= '0;
      cmd_prev    <= 1'b0;
      armed       <= 1'b0;
    end else begin
      cmd_prev    <= cmd;
      armed       <= armed | ~cmd;
      aen1        <= ~en;
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          rdy1 <= 1'b1;
          if (start) begin
            tcnt <= '0;
            if (n != '0) begin
              state <= WAIT;
              wcnt  <= n - ONE;
              rdy1  <= 1'b0;
            end else begin
              state <= EXTEND;
            end
          end
        end
        WAIT: begin
          if (!cmd) begin
            state <= IDLE;
            rdy1  <= 1'b1;
          end else begin
            tcnt <= tcnt + ONE;
            // last base wait clock also takes the first ready decision
            if (wcnt != '0) begin
              wcnt <= wcnt - ONE;
            end else if (rdy_s) begin
              state <= HOLD;
              rdy1  <= 1'b1;
            end else begin
              state <= EXTEND;
            end
          end
        end
        EXTEND: begin
          if (!cmd) begin
            state <= IDLE;
            rdy1  <= 1'b1;
          end else if (!rdy1 && tcnt == TLIM) begin
            state       <= HOLD;
            rdy1        <= 1'b1;
            timeout_err <= 1'b1;
          end else if (rdy_s) begin
            state <= HOLD;
            rdy1  <= 1'b1;
          end else begin
            rdy1 <= 1'b0;
            if (!rdy1)
              tcnt <= tcnt + ONE;
          end
        end
        HOLD: begin
          rdy1 <= 1'b1;
          if (!cmd)
            state <= IDLE;
        end
        default: begin
          state <= IDLE;
          rdy1  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wait_state_gen.sv
// Directed and randomized bench for wait_state_gen against a cycle model.
module tb_wait_state_gen;
  import wait_pkg::*;

  localparam int IOW = 1;
  localparam int MEMW = 0;
  localparam int DMAW = 1;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic ior_n = 1'b1;
  logic iow_n = 1'b1;
  logic memr_n = 1'b1;
  logic memw_n = 1'b1;
  logic dma_ack = 1'b0;
  logic io_ch_rdy = 1'b1;
  logic rdy1;
  logic aen1;
  logic timeout_err;

  int checks = 0;
  int errors = 0;
  int lowclk = 0;
  int errpulse = 0;

  // reference model state
  bit m_busy, m_held, m_prev, m_armed;
  bit m_rdy, m_err, m_aen;
  bit io_d1, io_d2;
  int m_j, m_n, m_low;

  wait_state_gen #(
    .IO_WAITS (IOW),
    .MEM_WAITS(MEMW),
    .DMA_WAITS(DMAW),
    .TIMEOUT  (TO),
    .CNT_W    (7)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .ior_n      (ior_n),
    .iow_n      (iow_n),
    .memr_n     (memr_n),
    .memw_n     (memw_n),
    .dma_ack    (dma_ack),
    .io_ch_rdy  (io_ch_rdy),
    .rdy1       (rdy1),
    .aen1       (aen1),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_held = 0; m_prev = 0; m_armed = 0;
    m_rdy = 1; m_err = 0; m_aen = 1;
    io_d1 = 1; io_d2 = 1;
    m_j = 0; m_n = 0; m_low = 0;
  endtask

  // Rules: N base clocks low; then release on synchronized ready,
  // or forced release once rdy1 has been low TO clocks; strobe drop aborts.
  task automatic model_edge();
    bit cio, c;
    cio = !ior_n || !iow_n;
    c = cio || !memr_n || !memw_n;
    m_err = 0;
    if (m_busy) begin
      if (!c) begin
        m_busy = 0;
        m_rdy = 1;
      end else begin
        m_j++;
        if (m_j >= ((m_n > 0) ? m_n : 1)) begin
          if (!m_rdy && m_low == TO) begin
            m_busy = 0; m_held = 1; m_rdy = 1; m_err = 1;
          end else if (io_d2) begin
            m_busy = 0; m_held = 1; m_rdy = 1;
          end else begin
            m_rdy = 0;
          end
        end
      end
    end else if (m_held) begin
      m_rdy = 1;
      if (!c) m_held = 0;
    end else if (c && !m_prev && en && m_armed) begin
      m_busy = 1;
      m_j = 0;
      m_n = (cio ? IOW : MEMW) + (dma_ack ? DMAW : 0);
      m_rdy = (m_n == 0);
    end else begin
      m_rdy = 1;
    end
    m_low = m_rdy ? 0 : m_low + 1;
    m_armed = m_armed || !c;
    m_prev = c;
    m_aen = !en;
    io_d2 = io_d1;
    io_d1 = io_ch_rdy;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    chk("rdy1", rdy1, m_rdy);
    chk("aen1", aen1, m_aen);
    chk("timeout_err", timeout_err, m_err);
    if (!rdy1) lowclk++;
    if (timeout_err) errpulse++;
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic clr();
    lowclk = 0;
    errpulse = 0;
  endtask

  task automatic idle_all();
    ior_n = 1; iow_n = 1; memr_n = 1; memw_n = 1;
  endtask

  initial begin
    int gap, len, sel;
    model_reset();
    steps(2);
    chk("reset_rdy1", rdy1, 1'b1);
    chk("reset_aen1", aen1, 1'b1);
    chk("reset_terr", timeout_err, 1'b0);
    rst_n = 1;
    steps(3);

    // I/O read, 1 base wait
    clr(); ior_n = 0; steps(6); ior_n = 1; steps(2);
    chki("io_read_low", lowclk, 1);
    chki("io_read_terr", errpulse, 0);

    // memory write, no waits
    clr(); memw_n = 0; steps(5); memw_n = 1; steps(2);
    chki("mem_write_low", lowclk, 0);
    chk("mem_write_idle", dut.state === IDLE, 1'b1);

    // DMA I/O write then plain I/O write
    clr(); dma_ack = 1; iow_n = 0; steps(6); iow_n = 1; steps(2);
    chki("dma_iow_low", lowclk, 2);
    clr(); dma_ack = 0; iow_n = 0; steps(6); iow_n = 1; steps(2);
    chki("iow_low", lowclk, 1);

    // slow device extends the cycle
    io_ch_rdy = 0; step();
    clr(); iow_n = 0; steps(10); io_ch_rdy = 1; steps(6);
    chki("extend_low", lowclk, 12);
    chki("extend_terr", errpulse, 0);
    iow_n = 1; steps(2);

    // stuck device: timeout
    io_ch_rdy = 0; step();
    clr(); ior_n = 0; steps(70);
    chki("timeout_low", lowclk, TO);
    chki("timeout_pulses", errpulse, 1);
    ior_n = 1; io_ch_rdy = 1; steps(2);
    chk("timeout_idle", dut.state === IDLE, 1'b1);

    // abort during WAIT
    dma_ack = 1; ior_n = 0; step();
    chk("abort_wait_low", rdy1, 1'b0);
    ior_n = 1; step();
    chk("abort_rdy1", rdy1, 1'b1);
    chk("abort_idle", dut.state === IDLE, 1'b1);
    steps(2);

    // reset mid-WAIT, strobe still low after release
    iow_n = 0; step();
    chk("rst_pre_low", rdy1, 1'b0);
    #2 rst_n = 0;
    #1 chk("rst_async_rdy1", rdy1, 1'b1);
    model_reset();
    steps(2);
    rst_n = 1;
    clr(); steps(5);
    chki("rst_no_wait", lowclk, 0);
    iow_n = 1; step();
    clr(); iow_n = 0; steps(5); iow_n = 1; steps(2);
    chki("rst_fresh_wait", lowclk, 2);
    dma_ack = 0;

    // disabled
    en = 0; step();
    chk("dis_aen1", aen1, 1'b1);
    clr(); ior_n = 0; steps(4); ior_n = 1; steps(2);
    chki("dis_low", lowclk, 0);
    en = 1; steps(2);
    chk("en_aen1", aen1, 1'b0);

    // randomized traffic against the model
    for (int k = 0; k < 60; k++) begin
      en = ($urandom_range(0, 7) != 0);
      dma_ack = ($urandom_range(0, 1) != 0);
      gap = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++) begin
        io_ch_rdy = ($urandom_range(0, 3) != 0);
        step();
      end
      sel = $urandom_range(0, 4);
      case (sel)
        0: ior_n = 0;
        1: iow_n = 0;
        2: memr_n = 0;
        3: memw_n = 0;
        default: begin ior_n = 0; memr_n = 0; end
      endcase
      len = $urandom_range(1, 20);
      for (int l = 0; l < len; l++) begin
        io_ch_rdy = ($urandom_range(0, 3) != 0);
        step();
      end
      idle_all();
    end
    io_ch_rdy = 1;
    steps(3);
    chk("final_idle", dut.state === IDLE, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
